// File: rtl/div_iterative_pkg.sv
// rtl/div_iterative_pkg.sv - shared op codes, state encoding and negate helper for div_iterative
package div_iterative_pkg;

    localparam int XW = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XW-1:0] XMIN = {1'b1, {(XW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [XW-1:0] negate(input logic [XW-1:0] x);
        return ~x + XW'(1);
    endfunction

endpackage

// File: rtl/div_iterative_addsub.sv
// rtl/div_iterative_addsub.sv - 32-bit adder/subtractor mapped onto a DSP slice
module div_iterative_addsub (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_addsubin,
    output logic [31:0] o_sum
);

    logic [31:0] w_b_eff;

    assign w_b_eff = i_addsubin ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {31'd0, i_addsubin};

endmodule

// File: rtl/div_iterative.sv
// rtl/div_iterative.sv - RV32M restoring divider, one quotient bit per cycle
module div_iterative
    import div_iterative_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t          r_state;
    state_t          w_next_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_dvs;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div0;
    logic            w_ovf;
    logic            w_early;
    logic [XLEN-1:0] w_s;
    logic [XLEN-1:0] w_d;
    logic            w_borrow;
    logic            w_ge;
    logic [XLEN-1:0] w_quot_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & dividend[XLEN-1];
    assign w_b_neg  = w_signed & divisor[XLEN-1];
    assign w_a_abs  = w_a_neg ? negate(dividend) : dividend;
    assign w_b_abs  = w_b_neg ? negate(divisor)  : divisor;
    assign w_div0   = (divisor == '0);
    assign w_ovf    = w_signed & (dividend == XMIN) & (divisor == '1);
    assign w_early  = EARLY_OUT & (w_div0 | w_ovf);

    // Shifted partial remainder; its 33rd bit is r_rem[XLEN-1], folded into w_ge.
    assign w_s      = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    assign w_borrow = (~w_s[XLEN-1] & r_dvs[XLEN-1]) |
                      (~(w_s[XLEN-1] ^ r_dvs[XLEN-1]) & w_d[XLEN-1]);
    assign w_ge     = r_rem[XLEN-1] | ~w_borrow;

    assign w_quot_fix = r_neg_q ? negate(r_q)   : r_q;
    assign w_rem_fix  = r_neg_r ? negate(r_rem) : r_rem;

    div_iterative_addsub u_addsub (
        .i_a        (w_s),
        .i_b        (r_dvs),
        .i_addsubin (1'b1),
        .o_sum      (w_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = w_early ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == 5'd0) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 5'd0;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_rem <= op[1];
                        if (w_early) begin
                            // Preloaded values are final, so the sign fix is disabled.
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_q     <= w_div0 ? '1 : XMIN;
                            r_rem   <= w_div0 ? dividend : '0;
                            r_cnt   <= 5'd0;
                        end else begin
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_q     <= w_a_abs;
                            r_dvs   <= w_b_abs;
                            r_rem   <= '0;
                            r_cnt   <= 5'd31;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_d : w_s;
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                end
                S_FIX: begin
                    r_result <= r_is_rem ? w_rem_fix : w_quot_fix;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_iterative.sv
// tb/tb_div_iterative.sv - scoreboard bench for div_iterative, early-out and full-iteration builds
module tb_div_iterative;
    import div_iterative_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy0, done0, busy1, done1;
    logic [31:0] result0, result1;

    always #5 clk = ~clk;

    div_iterative #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy0), .done(done0), .result(result0)
    );

    div_iterative #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_slow (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy1), .done(done1), .result(result1)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] lat;
        logic [63:0] t_acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_done0 = 0;
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] qv, rv;
        sgn = ~o[0];
        if (b == 32'd0) begin
            qv = 32'hFFFF_FFFF;
            rv = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            qv = 32'h8000_0000;
            rv = 32'd0;
        end else if (sgn) begin
            qv = $signed(a) / $signed(b);
            rv = $signed(a) % $signed(b);
        end else begin
            qv = a / b;
            rv = a % b;
        end
        return o[1] ? rv : qv;
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Drives from the current point; the next rising edge is the accept edge.
    task automatic issue_now(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
        exp_t e;
        op = o;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        e.res   = ref_result(o, a, b);
        e.t_acc = $time;
        e.lat   = is_special(o, a, b) ? 32'd2 : 32'd34;
        q0.push_back(e);
        e.lat   = 32'd34;
        q1.push_back(e);
        #1;
        if (!hold) start = 1'b0;
        op = 2'($urandom_range(3));
        dividend = $urandom;
        divisor = $urandom;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue_now(o, a, b, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            check("done_timeout", q0.size() + q1.size(), 32'd0);
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done0) begin
                n_done0++;
                if (q0.size() == 0) begin
                    check("fast_spurious_done", {31'd0, done0}, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    check("fast_result", result0, e0.res);
                    check("fast_latency", 32'(($time - e0.t_acc + 5) / 10), e0.lat);
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    check("slow_spurious_done", {31'd0, done1}, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("slow_result", result1, e1.res);
                    check("slow_latency", 32'(($time - e1.t_acc + 5) / 10), e1.lat);
                end
            end
            if (done0 && prev_done0) check("fast_done_width", {31'd0, done0}, 32'd0);
            if (done1 && prev_done1) check("slow_done_width", {31'd0, done1}, 32'd0);
        end
        prev_done0 = done0;
        prev_done1 = done1;
    end

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        check("reset_result", result0, 32'd0);
        check("reset_slow_busy", {31'd0, busy1}, 32'd0);
        check("reset_slow_result", result1, 32'd0);
        rst_n = 1'b1;

        run(OP_DIVU, 32'd100, 32'd7);
        run(OP_REMU, 32'd100, 32'd7);
        run(OP_DIV,  32'hFFFF_FFF9, 32'd2);
        run(OP_REM,  32'hFFFF_FFF9, 32'd2);
        run(OP_DIV,  32'd7, 32'hFFFF_FFFE);
        run(OP_REM,  32'd7, 32'hFFFF_FFFE);
        run(OP_DIVU, 32'd5, 32'd0);
        run(OP_REM,  32'hFFFF_FFFB, 32'd0);
        run(OP_REMU, 32'd5, 32'd0);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000);
        run(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
        run(OP_DIV,  32'h8000_0000, 32'd3);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] b;
            b = $urandom;
            if (i[0]) b = b >> $urandom_range(31);
            if (b == 32'd0) b = 32'd9;
            run(2'($urandom_range(3)), $urandom, b);
        end

        // start held through the busy window is not accepted a second time
        @(negedge clk);
        issue_now(OP_DIVU, 32'd1000, 32'd3, 1'b1);
        repeat (10) @(negedge clk);
        check("hold_busy", {31'd0, busy0}, 32'd1);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // back-to-back: new request accepted in the done cycle
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 60 && !done0; i++) @(negedge clk);
        check("b2b_first_done", {31'd0, done0}, 32'd1);
        issue_now(OP_REMU, 32'd1000, 32'd7, 1'b0);
        @(negedge clk);
        check("b2b_result_held", result0, 32'd14);
        check("b2b_busy", {31'd0, busy0}, 32'd1);
        wait_idle();

        // asynchronous reset in the middle of an iteration
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        check("pre_reset_busy", {31'd0, busy0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy0}, 32'd0);
        check("abort_done", {31'd0, done0}, 32'd0);
        check("abort_result", result0, 32'd0);
        check("abort_slow_busy", {31'd0, busy1}, 32'd0);
        check("abort_slow_result", result1, 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap = n_done0;
        repeat (45) @(negedge clk);
        check("no_done_after_abort", n_done0 - snap, 32'd0);

        run(OP_REM, 32'hFFFF_FF9C, 32'd7);
        check("drain", q0.size() + q1.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
